cpu_int_ctrl: RTL and testbench
===============================

Name: cpu_int_ctrl

Overview:
- Sits on the CPU side of the 6502C core and drives the core's nmi, irq and RDY inputs from system-level events.
- Latches and masks interrupt sources, then presents an IRQ level and a fixed-width NMI pulse.
- Arbitrates DMA halt requests by deasserting RDY with a req/gnt handshake.
- Takes SYNC from the core so halts and NMI pulses align with instruction boundaries.

Parameters:
- NUM_IRQ, 4, number of maskable IRQ sources (1..8).
- NMI_PULSE, 2, cycles nmi is held asserted per NMI event (>=1).
- HALT_WAIT, 3, phi1 cycles between RDY deassert and dma_gnt (covers 6502 write cycles that ignore RDY).

Ports:
- phi1  in  1  system clock; all state updates on posedge phi1
- rst_n  in  1  asynchronous active-low reset
- irq_src  in  NUM_IRQ  IRQ sources; rising edge sets pending bit
- nmi_src  in  1  NMI source; rising edge starts an NMI event
- reg_we  in  1  register write strobe, one cycle
- reg_sel  in  1  0 = enable mask, 1 = pending-clear (write-1-to-clear)
- reg_wdata  in  8  write data; bits [NUM_IRQ-1:0] used
- pending  out  NUM_IRQ  raw pending bits (unmasked)
- SYNC  in  1  opcode-fetch cycle indicator from the CPU FSM
- dma_req  in  1  DMA wants the bus; level, held until dma_gnt seen and work done
- dma_gnt  out  1  bus granted; CPU halted
- nmi  out  1  active-high NMI request to the CPU
- irq  out  1  active-high IRQ level to the CPU
- RDY  out  1  CPU ready; 0 halts the CPU

Behaviour:
- Reset values: pending=0, mask=0, nmi=0, irq=1'b0, RDY=1, dma_gnt=0, all state idle. Reset mid-halt releases RDY asynchronously.
- Edge detect:
  - Sources are registered one stage; an edge is prev=0, cur=1.
  - A source that is high at reset exit produces no edge.
- Pending:
  - pending[i] sets on an edge and clears when written 1 with reg_sel=1.
  - If a set and a clear hit the same cycle, set wins.
- Mask: written when reg_sel=0.
- irq = |(pending & mask), registered, 1-cycle latency from pending or mask change.
- NMI FSM, states N_IDLE, N_WAIT, N_PULSE:
  - N_IDLE goes to N_WAIT on an nmi_src edge.
  - N_WAIT goes to N_PULSE on the first cycle with SYNC=1.
  - N_PULSE drives nmi=1 for exactly NMI_PULSE cycles, then returns to N_IDLE.
  - An edge arriving during N_WAIT or N_PULSE sets a one-deep nmi_queued flag. It is consumed on return to N_IDLE (straight to N_WAIT). Further edges are dropped.
- Halt FSM, states H_RUN, H_DRAIN, H_GRANT:
  - H_RUN: with dma_req=1, go to H_DRAIN and set RDY=0 next cycle.
  - H_DRAIN: 3-bit counter counts HALT_WAIT cycles, then go to H_GRANT.
  - H_GRANT: dma_gnt=1, RDY=0.
  - dma_req falling in H_DRAIN or H_GRANT returns to H_RUN: RDY=1 and dma_gnt=0 on the next cycle, counter cleared.
  - The NMI and IRQ outputs keep updating while halted; the NMI pulse stretches until RDY=1 (counter frozen while RDY=0).
- No combinational path from any input to any output.

Optional Feature:
IRQ_PRIORITY_EN
- Defined: adds output irq_id [2:0], the index of the lowest-numbered set bit of pending&mask, registered alongside irq. irq_id=0 when irq=0.
- Undefined: port absent, no encoder logic.

Decomposition:
- Shared package cpu_int_pkg holds:
  - NMI and halt state encodings as `define constants, in the same style as the existing FSM state defines.
  - REG_MASK=1'b0 and REG_CLR=1'b1.
- One sub-module, int_edge_latch: per-source edge detect plus pending set/clear, instantiated NUM_IRQ times.

Test Plan:
- Reset release with irq_src=4'b0001 held high -> pending=0, irq=0. Drop the source, raise it again -> pending=0001 one cycle after the edge; with mask 0 written, irq stays 0.
- Write mask=8'h05, pulse irq_src[2] -> irq=1 after 2 cycles. Write reg_sel=1 data=8'h04 -> irq=0 next cycle. With IRQ_PRIORITY_EN, pulse sources 2 and 0 together -> irq_id=0.
- nmi_src edge while SYNC=0 for 5 cycles, then SYNC=1 -> nmi high exactly 2 cycles starting the cycle after SYNC. A second nmi_src edge during the pulse -> second 2-cycle pulse at the next SYNC.
- Raise dma_req -> RDY=0 next cycle, dma_gnt=1 after 3 more cycles. Drop dma_req -> RDY=1 and dma_gnt=0 next cycle.
- nmi pulse active with dma_req rising mid-pulse -> nmi stays high until RDY returns, total 2 un-halted high cycles.
- Assert rst_n low mid-H_GRANT between clock edges -> RDY=1 and dma_gnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_int_pkg.sv
// Shared encodings for the 6502C interrupt/halt controller.
// Build option IRQ_PRIORITY_EN (see cpu_int_ctrl) needs nothing extra here.
`ifndef CPU_INT_PKG_DEFINES
`define CPU_INT_PKG_DEFINES
`define NMI_ST_IDLE   2'd0
`define NMI_ST_WAIT   2'd1
`define NMI_ST_PULSE  2'd2
`define HALT_ST_RUN   2'd0
`define HALT_ST_DRAIN 2'd1
`define HALT_ST_GRANT 2'd2
`endif

package cpu_int_pkg;

    localparam logic REG_MASK = 1'b0;
    localparam logic REG_CLR  = 1'b1;

    localparam int unsigned HALT_CNT_W = 3;

    typedef enum logic [1:0] {
        N_IDLE  = `NMI_ST_IDLE,
        N_WAIT  = `NMI_ST_WAIT,
        N_PULSE = `NMI_ST_PULSE
    } nmi_state_t;

    typedef enum logic [1:0] {
        H_RUN   = `HALT_ST_RUN,
        H_DRAIN = `HALT_ST_DRAIN,
        H_GRANT = `HALT_ST_GRANT
    } halt_state_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/int_edge_latch.sv
// One IRQ source: rising-edge detect feeding a write-1-to-clear pending bit.
module int_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic clr,
    output logic pending
);

    logic src_q;
    logic rise_c;

    // Previous sample resets high so a source already asserted at reset exit is not an edge.
    assign rise_c = src & ~src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= 1'b1;
            pending <= 1'b0;
        end else begin
            src_q <= src;
            if (rise_c) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_int_ctrl.sv
// Drives the 6502C nmi/irq/RDY inputs: IRQ latching and masking, SYNC-aligned NMI pulses, DMA halt handshake.
// Define IRQ_PRIORITY_EN to add the irq_id output (lowest active source index).
module cpu_int_ctrl
    import cpu_int_pkg::*;
#(
    parameter int unsigned NUM_IRQ   = 4,
    parameter int unsigned NMI_PULSE = 2,
    parameter int unsigned HALT_WAIT = 3
) (
    input  logic               phi1,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               nmi_src,
    input  logic               reg_we,
    input  logic               reg_sel,
    input  logic [7:0]         reg_wdata,
    output logic [NUM_IRQ-1:0] pending,
    input  logic               SYNC,
    input  logic               dma_req,
    output logic               dma_gnt,
    output logic               nmi,
    output logic               irq,
`ifdef IRQ_PRIORITY_EN
    output logic [2:0]         irq_id,
`endif
    output logic               RDY
);

    localparam int unsigned NMI_CNT_W = (NMI_PULSE > 1) ? $clog2(NMI_PULSE) : 1;
    localparam logic [NMI_CNT_W-1:0]  NMI_LAST  = NMI_CNT_W'(NMI_PULSE - 1);
    localparam logic [HALT_CNT_W-1:0] HALT_LAST = HALT_CNT_W'((HALT_WAIT > 0) ? HALT_WAIT - 1 : 0);

    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] clr_c;
    logic [NUM_IRQ-1:0] live_c;
    logic               unused_wdata;

    logic                  nmi_src_q;
    logic                  nmi_edge_c;
    nmi_state_t            n_state, n_state_nx;
    logic                  n_queued, n_queued_nx;
    logic [NMI_CNT_W-1:0]  n_cnt, n_cnt_nx;

    halt_state_t           h_state, h_state_nx;
    logic [HALT_CNT_W-1:0] h_cnt, h_cnt_nx;

    assign clr_c        = {NUM_IRQ{reg_we && (reg_sel == REG_CLR)}} & reg_wdata[NUM_IRQ-1:0];
    assign live_c       = pending & mask;
    assign unused_wdata = ^reg_wdata;
    assign nmi_edge_c   = nmi_src & ~nmi_src_q;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
        int_edge_latch u_latch (
            .clk     (phi1),
            .rst_n   (rst_n),
            .src     (irq_src[i]),
            .clr     (clr_c[i]),
            .pending (pending[i])
        );
    end

    // NMI sequencing; the pulse counter only advances on cycles the CPU is running.
    always_comb begin
        n_state_nx  = n_state;
        n_queued_nx = n_queued;
        n_cnt_nx    = n_cnt;
        case (n_state)
            N_IDLE: begin
                if (nmi_edge_c) n_state_nx = N_WAIT;
            end
            N_WAIT: begin
                if (nmi_edge_c) n_queued_nx = 1'b1;
                if (SYNC) begin
                    n_state_nx = N_PULSE;
                    n_cnt_nx   = '0;
                end
            end
            N_PULSE: begin
                if (nmi_edge_c) n_queued_nx = 1'b1;
                if (RDY) begin
                    if (n_cnt == NMI_LAST) begin
                        n_cnt_nx    = '0;
                        n_queued_nx = 1'b0;
                        n_state_nx  = (n_queued || nmi_edge_c) ? N_WAIT : N_IDLE;
                    end else begin
                        n_cnt_nx = n_cnt + 1'b1;
                    end
                end
            end
            default: begin
                n_state_nx  = N_IDLE;
                n_queued_nx = 1'b0;
                n_cnt_nx    = '0;
            end
        endcase
    end

    // DMA halt: drop RDY, wait out RDY-ignoring write cycles, then grant.
    always_comb begin
        h_state_nx = h_state;
        h_cnt_nx   = h_cnt;
        case (h_state)
            H_RUN: begin
                if (dma_req) begin
                    h_state_nx = H_DRAIN;
                    h_cnt_nx   = '0;
                end
            end
            H_DRAIN: begin
                if (!dma_req) begin
                    h_state_nx = H_RUN;
                    h_cnt_nx   = '0;
                end else if (h_cnt == HALT_LAST) begin
                    h_state_nx = H_GRANT;
                    h_cnt_nx   = '0;
                end else begin
                    h_cnt_nx = h_cnt + 1'b1;
                end
            end
            H_GRANT: begin
                if (!dma_req) begin
                    h_state_nx = H_RUN;
                    h_cnt_nx   = '0;
                end
            end
            default: begin
                h_state_nx = H_RUN;
                h_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge phi1 or negedge rst_n) begin
        if (!rst_n) begin
            mask      <= '0;
            nmi_src_q <= 1'b1;
            n_state   <= N_IDLE;
            n_queued  <= 1'b0;
            n_cnt     <= '0;
            h_state   <= H_RUN;
            h_cnt     <= '0;
            nmi       <= 1'b0;
            irq       <= 1'b0;
            RDY       <= 1'b1;
            dma_gnt   <= 1'b0;
        end else begin
            if (reg_we && (reg_sel == REG_MASK)) mask <= reg_wdata[NUM_IRQ-1:0];
            nmi_src_q <= nmi_src;
            n_state   <= n_state_nx;
            n_queued  <= n_queued_nx;
            n_cnt     <= n_cnt_nx;
            h_state   <= h_state_nx;
            h_cnt     <= h_cnt_nx;
            nmi       <= (n_state_nx == N_PULSE);
            irq       <= |live_c;
            RDY       <= (h_state_nx == H_RUN);
            dma_gnt   <= (h_state_nx == H_GRANT);
        end
    end

`ifdef IRQ_PRIORITY_EN
    always_ff @(posedge phi1 or negedge rst_n) begin
        if (!rst_n) begin
            irq_id <= 3'd0;
        end else begin
            irq_id <= lowest_set(8'(live_c));
        end
    end
`endif

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Scoreboard bench for cpu_int_ctrl: directed scenarios plus random traffic against an event-level model.
module tb_cpu_int_ctrl;

    localparam int NUM_IRQ   = 4;
    localparam int NMI_PULSE = 2;
    localparam int HALT_WAIT = 3;

    logic       phi1;
    logic       rst_n;
    logic [3:0] irq_src;
    logic       nmi_src;
    logic       reg_we;
    logic       reg_sel;
    logic [7:0] reg_wdata;
    logic [3:0] pending;
    logic       SYNC;
    logic       dma_req;
    logic       dma_gnt;
    logic       nmi;
    logic       irq;
    logic       RDY;
`ifdef IRQ_PRIORITY_EN
    logic [2:0] irq_id;
`endif

    cpu_int_ctrl #(
        .NUM_IRQ   (NUM_IRQ),
        .NMI_PULSE (NMI_PULSE),
        .HALT_WAIT (HALT_WAIT)
    ) dut (
        .phi1      (phi1),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .nmi_src   (nmi_src),
        .reg_we    (reg_we),
        .reg_sel   (reg_sel),
        .reg_wdata (reg_wdata),
        .pending   (pending),
        .SYNC      (SYNC),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .nmi       (nmi),
        .irq       (irq),
`ifdef IRQ_PRIORITY_EN
        .irq_id    (irq_id),
`endif
        .RDY       (RDY)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    typedef struct packed {
        logic [3:0] pending;
        logic       irq;
        logic [2:0] id;
        logic       nmi;
        logic       rdy;
        logic       gnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: event rules kept as flags and remaining-cycle counts.
    logic [3:0] m_pend, m_mask, m_prev;
    logic       m_nprev;
    bit         m_first;
    bit         m_wait, m_queued;
    int         m_left;
    bit         m_halted;
    int         m_age;

    task automatic model_reset();
        m_pend   = '0;
        m_mask   = '0;
        m_prev   = '0;
        m_nprev  = 1'b0;
        m_first  = 1;
        m_wait   = 0;
        m_queued = 0;
        m_left   = 0;
        m_halted = 0;
        m_age    = 0;
    endtask

    task automatic model_step(output exp_t e);
        logic [3:0] live, rose;
        logic       nrose;
        bit         running, pend_evt;
        live   = m_pend & m_mask;
        e.irq  = |live;
        e.id   = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (live[i]) e.id = 3'(i);
        rose   = m_first ? 4'b0 : (irq_src & ~m_prev);
        nrose  = m_first ? 1'b0 : (nmi_src & ~m_nprev);
        m_prev = irq_src;
        m_nprev = nmi_src;
        m_first = 0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (rose[i]) m_pend[i] = 1'b1;
            else if (reg_we && reg_sel && reg_wdata[i]) m_pend[i] = 1'b0;
        end
        if (reg_we && !reg_sel) m_mask = reg_wdata[3:0];

        running = !m_halted;
        if (m_left > 0) begin
            pend_evt = m_queued || nrose;
            if (running) m_left--;
            if (m_left == 0) begin
                m_wait   = pend_evt;
                m_queued = 0;
            end else begin
                m_queued = pend_evt;
            end
        end else if (m_wait) begin
            if (nrose) m_queued = 1;
            if (SYNC) begin
                m_wait = 0;
                m_left = NMI_PULSE;
            end
        end else if (nrose) begin
            m_wait = 1;
        end

        if (!m_halted) begin
            if (dma_req) begin
                m_halted = 1;
                m_age    = 0;
            end
        end else if (!dma_req) begin
            m_halted = 0;
        end else if (m_age < HALT_WAIT) begin
            m_age++;
        end

        e.pending = m_pend;
        e.nmi     = (m_left > 0);
        e.rdy     = !m_halted;
        e.gnt     = m_halted && (m_age >= HALT_WAIT);
    endtask

    // Called at a falling edge: apply inputs, queue the response expected after the next rising edge.
    task automatic drive(input logic [3:0] isrc, input logic nsrc, input logic we, input logic sel,
                         input logic [7:0] wd, input logic sync, input logic dreq);
        exp_t e;
        irq_src   = isrc;
        nmi_src   = nsrc;
        reg_we    = we;
        reg_sel   = sel;
        reg_wdata = wd;
        SYNC      = sync;
        dma_req   = dreq;
        model_step(e);
        exp_q.push_back(e);
        @(negedge phi1);
    endtask

    task automatic idle(input int n, input logic [3:0] isrc, input logic nsrc, input logic dreq);
        for (int k = 0; k < n; k++) drive(isrc, nsrc, 1'b0, 1'b0, 8'h00, 1'b0, dreq);
    endtask

    always @(posedge phi1) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pending", int'(pending), int'(e.pending));
            check("irq",     int'(irq),     int'(e.irq));
            check("nmi",     int'(nmi),     int'(e.nmi));
            check("RDY",     int'(RDY),     int'(e.rdy));
            check("dma_gnt", int'(dma_gnt), int'(e.gnt));
`ifdef IRQ_PRIORITY_EN
            check("irq_id",  int'(irq_id),  int'(e.id));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r_isrc;
        logic       r_nsrc, r_dreq;
        rst_n = 1'b0;
        irq_src = 4'b0001; nmi_src = 1'b0; reg_we = 1'b0; reg_sel = 1'b0;
        reg_wdata = 8'h00; SYNC = 1'b0; dma_req = 1'b0;
        model_reset();
        repeat (3) @(negedge phi1);
        check("reset pending", int'(pending), 0);
        check("reset irq",     int'(irq),     0);
        check("reset nmi",     int'(nmi),     0);
        check("reset RDY",     int'(RDY),     1);
        check("reset dma_gnt", int'(dma_gnt), 0);
        rst_n = 1'b1;

        // Source high through reset exit: no edge; then a real edge with mask cleared
        idle(3, 4'b0001, 1'b0, 1'b0);
        idle(1, 4'b0000, 1'b0, 1'b0);
        idle(2, 4'b0001, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);

        // Mask 0x05, pulse source 2, then clear it
        drive(4'b0000, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
        idle(1, 4'b0100, 1'b0, 1'b0);
        idle(3, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        idle(2, 4'b0000, 1'b0, 1'b0);
        // Sources 2 and 0 together, then set and clear colliding on source 0
        idle(1, 4'b0101, 1'b0, 1'b0);
        idle(3, 4'b0000, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        idle(2, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b1, 1'b1, 8'h0f, 1'b0, 1'b0);
        idle(1, 4'b0000, 1'b0, 1'b0);

        // NMI waits for SYNC; a second edge during the pulse is queued
        idle(5, 4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(1, 4'b0000, 1'b1, 1'b0);
        idle(4, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(4, 4'b0000, 1'b0, 1'b0);

        // DMA halt request and release
        idle(6, 4'b0000, 1'b0, 1'b1);
        idle(3, 4'b0000, 1'b0, 1'b0);

        // NMI pulse stretched by a halt starting mid-pulse
        idle(1, 4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(1, 4'b0000, 1'b0, 1'b0);
        idle(8, 4'b0000, 1'b0, 1'b1);
        idle(5, 4'b0000, 1'b0, 1'b0);

        // Asynchronous reset while granted
        idle(6, 4'b0000, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async RDY",     int'(RDY),     1);
        check("async dma_gnt", int'(dma_gnt), 0);
        @(negedge phi1);
        dma_req = 1'b0;
        model_reset();
        rst_n = 1'b1;

        // Random traffic
        r_isrc = 4'b0000; r_nsrc = 1'b0; r_dreq = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            logic       we, sel, sync;
            logic [7:0] wd;
            r_isrc ^= 4'($urandom) & 4'($urandom) & 4'($urandom);
            if ($urandom_range(5) == 0) r_nsrc = ~r_nsrc;
            if ($urandom_range(19) == 0) r_dreq = ~r_dreq;
            we   = ($urandom_range(7) == 0);
            sel  = 1'($urandom);
            wd   = 8'($urandom);
            sync = ($urandom_range(2) == 0);
            drive(r_isrc, r_nsrc, we, sel, wd, sync, r_dreq);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge phi1);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
